// File: rtl/utils_top.sv
// Shared decode-side types: scoreboard slot layout and the x0 index.
// No ports; imported by decode_scoreboard and decode_fwd_sel.
package utils_top;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } sb_slot_t;

    // A slot produces the source when it is a live write to a non-x0 rd
    // equal to the source, and the source is actually read.
    function automatic logic slot_match(sb_slot_t s, logic [4:0] src,
                                        logic re);
        return s.vld & s.we & (s.rd != REG_ZERO) & (s.rd == src) & re;
    endfunction

endpackage

// File: rtl/decode_fwd_sel.sv
// Per-operand producer select: finds the youngest matching slot.
// Ports: slots/src/re/fwd_dat/rgf_dat in; dat (operand), hazard out.
module decode_fwd_sel
    import utils_top::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 3,
    parameter int LD_LAT = 1
) (
    input  sb_slot_t [DEPTH-1:0]    slots,
    input  logic [4:0]              src,
    input  logic                    re,
    input  logic [DEPTH*XLEN-1:0]   fwd_dat,
    input  logic [XLEN-1:0]         rgf_dat,
    output logic [XLEN-1:0]         dat,
    output logic                    hazard
);

    logic            hit;
    logic            rdy;
    logic [XLEN-1:0] fsel;

    // Walk oldest to youngest so the youngest match overwrites the rest.
    // hazard never looks at fwd_dat, keeping stall off the data path.
    always_comb begin
        hit  = 1'b0;
        rdy  = 1'b0;
        fsel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slot_match(slots[k], src, re)) begin
                hit  = 1'b1;
                rdy  = ~(slots[k].ld & (k < LD_LAT));
                fsel = fwd_dat[k*XLEN +: XLEN];
            end
        end
        hazard = hit & ~rdy;
        dat    = (hit & rdy) ? fsel : rgf_dat;
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode hazard/forwarding unit: shift-register scoreboard of in-flight
// destinations, load-use stall, operand forwarding, stall counter.
// Ports: dec_* decode fields, flush, rgf_rd1/2, fwd_dat in;
//        rs1_dat/rs2_dat, stall, issue, stall_cnt out.
module decode_scoreboard
    import utils_top::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 3,
    parameter int LD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dec_vld,
    input  logic [4:0]            dec_rs1,
    input  logic [4:0]            dec_rs2,
    input  logic                  dec_rs1_re,
    input  logic                  dec_rs2_re,
    input  logic [4:0]            dec_rd,
    input  logic                  dec_we,
    input  logic                  dec_is_load,
    input  logic                  flush,
    input  logic [XLEN-1:0]       rgf_rd1,
    input  logic [XLEN-1:0]       rgf_rd2,
    input  logic [DEPTH*XLEN-1:0] fwd_dat,
    output logic [XLEN-1:0]       rs1_dat,
    output logic [XLEN-1:0]       rs2_dat,
    output logic                  stall,
    output logic                  issue,
    output logic [CNT_W-1:0]      stall_cnt
);

    sb_slot_t [DEPTH-1:0] slots;
    sb_slot_t             slot_in;
    logic                 haz1;
    logic                 haz2;

    decode_fwd_sel #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .LD_LAT (LD_LAT)
    ) u_sel1 (
        .slots   (slots),
        .src     (dec_rs1),
        .re      (dec_rs1_re),
        .fwd_dat (fwd_dat),
        .rgf_dat (rgf_rd1),
        .dat     (rs1_dat),
        .hazard  (haz1)
    );

    decode_fwd_sel #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .LD_LAT (LD_LAT)
    ) u_sel2 (
        .slots   (slots),
        .src     (dec_rs2),
        .re      (dec_rs2_re),
        .fwd_dat (fwd_dat),
        .rgf_dat (rgf_rd2),
        .dat     (rs2_dat),
        .hazard  (haz2)
    );

    // flush dominates: a killed instruction neither stalls nor issues.
    assign stall = dec_vld & ~flush & (haz1 | haz2);
    assign issue = dec_vld & ~stall & ~flush;

    always_comb begin
        slot_in = '0;
        if (issue) begin
            slot_in.vld = 1'b1;
            slot_in.rd  = dec_rd;
            slot_in.we  = dec_we;
            slot_in.ld  = dec_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots     <= '0;
            stall_cnt <= '0;
        end else begin
            slots <= {slots[DEPTH-2:0], slot_in};
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: instance a (DEPTH 3, LD_LAT 1, CNT_W 4)
// and instance b (DEPTH 4, LD_LAT 2) share decode stimulus.
module tb_decode_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_vld, dec_rs1_re, dec_rs2_re;
    logic        dec_we, dec_is_load, flush;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [31:0] rgf_rd1, rgf_rd2;
    logic [95:0]  fwd_a;
    logic [127:0] fwd_b;
    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;
    logic        stall_a, issue_a, stall_b, issue_b;
    logic [3:0]  cnt_a;
    logic [31:0] cnt_b;

    localparam logic [31:0] RGF1 = 32'h1111_1111;
    localparam logic [31:0] RGF2 = 32'h2222_2222;

    typedef struct {
        string       name;
        bit          inst;
        bit          chk;
        logic        stall;
        logic        issue;
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    exp_t exp_q[$];
    int   ncmp = 0;
    int   nbad = 0;

    always #5 clk = ~clk;

    decode_scoreboard #(.XLEN(32), .DEPTH(3), .LD_LAT(1), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .dec_vld(dec_vld),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_re(dec_rs1_re), .dec_rs2_re(dec_rs2_re),
        .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
        .flush(flush), .rgf_rd1(rgf_rd1), .rgf_rd2(rgf_rd2),
        .fwd_dat(fwd_a), .rs1_dat(rs1_a), .rs2_dat(rs2_a),
        .stall(stall_a), .issue(issue_a), .stall_cnt(cnt_a)
    );

    decode_scoreboard #(.XLEN(32), .DEPTH(4), .LD_LAT(2), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .dec_vld(dec_vld),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_re(dec_rs1_re), .dec_rs2_re(dec_rs2_re),
        .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
        .flush(flush), .rgf_rd1(rgf_rd1), .rgf_rd2(rgf_rd2),
        .fwd_dat(fwd_b), .rs1_dat(rs1_b), .rs2_dat(rs2_b),
        .stall(stall_b), .issue(issue_b), .stall_cnt(cnt_b)
    );

    function automatic exp_t mk(string n, bit inst, bit chk, logic st,
                                logic is, logic [31:0] r1,
                                logic [31:0] r2);
        exp_t e;
        e.name = n; e.inst = inst; e.chk = chk;
        e.stall = st; e.issue = is; e.r1 = r1; e.r2 = r2;
        return e;
    endfunction

    task automatic set_dec(logic v, logic [4:0] s1, logic [4:0] s2,
                           logic re1, logic re2, logic [4:0] rd,
                           logic we, logic ld, logic fl);
        dec_vld = v; dec_rs1 = s1; dec_rs2 = s2;
        dec_rs1_re = re1; dec_rs2_re = re2;
        dec_rd = rd; dec_we = we; dec_is_load = ld; flush = fl;
    endtask

    task automatic defaults();
        set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rgf_rd1 = RGF1;
        rgf_rd2 = RGF2;
        for (int k = 0; k < 3; k++) fwd_a[k*32 +: 32] = 32'hA000_0000 + k;
        for (int k = 0; k < 4; k++) fwd_b[k*32 +: 32] = 32'hB000_0000 + k;
    endtask

    task automatic do_reset();
        defaults();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [65:0] obs, req;
        defaults();
        rst = 1'b1;
        set_dec(1, 5, 6, 1, 1, 7, 1, 1, 0);
        exp_q.push_back(mk("reset_outs", 0, 1, 0, 1, RGF1, RGF2));
        #2;
        e = exp_q.pop_front();
        obs = {stall_a, issue_a, rs1_a, rs2_a};
        req = {e.stall, e.issue, e.r1, e.r2};
        ncmp++;
        if (obs !== req) begin
            nbad++;
            $display("FAIL %s: got %h want %h", e.name, obs, req);
        end
        ncmp++;
        if (cnt_a !== 4'd0 || cnt_b !== 32'd0) begin
            nbad++;
            $display("FAIL reset_cnt: got %h/%h want 0/0", cnt_a, cnt_b);
        end
        @(negedge clk);
        rst = 1'b0;
        defaults();
    endtask

    task automatic test_load_use_lat1();
        exp_t e;
        logic [65:0] obs, req;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: begin
                    set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
                    exp_q.push_back(mk("lu1_load", 0, 1, 0, 1, RGF1, RGF2));
                end
                1: begin
                    set_dec(1, 5, 1, 1, 1, 6, 1, 0, 0);
                    exp_q.push_back(mk("lu1_stall", 0, 0, 1, 0, 0, 0));
                end
                default: exp_q.push_back(mk("lu1_issue", 0, 1, 0, 1,
                                            32'hA000_0001, RGF2));
            endcase
            #2;
            e = exp_q.pop_front();
            obs = {stall_a, issue_a, rs1_a, rs2_a};
            req = {e.stall, e.issue, e.r1, e.r2};
            if (!e.chk) begin obs[63:0] = '0; req[63:0] = '0; end
            ncmp++;
            if (obs !== req) begin
                nbad++;
                $display("FAIL %s: got %h want %h", e.name, obs, req);
            end
            if (c == 2) begin
                ncmp++;
                if (cnt_a !== 4'd1) begin
                    nbad++;
                    $display("FAIL lu1_cnt: got %0d want 1", cnt_a);
                end
            end
            @(negedge clk);
        end
        defaults();
    endtask

    task automatic test_load_use_lat2();
        exp_t e;
        logic [65:0] obs, req;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin
                    set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
                    exp_q.push_back(mk("lu2_load", 1, 1, 0, 1, RGF1, RGF2));
                end
                1: begin
                    set_dec(1, 5, 1, 1, 1, 6, 1, 0, 0);
                    exp_q.push_back(mk("lu2_stall0", 1, 0, 1, 0, 0, 0));
                end
                2: exp_q.push_back(mk("lu2_stall1", 1, 0, 1, 0, 0, 0));
                default: exp_q.push_back(mk("lu2_issue", 1, 1, 0, 1,
                                            32'hB000_0002, RGF2));
            endcase
            #2;
            e = exp_q.pop_front();
            obs = {stall_b, issue_b, rs1_b, rs2_b};
            req = {e.stall, e.issue, e.r1, e.r2};
            if (!e.chk) begin obs[63:0] = '0; req[63:0] = '0; end
            ncmp++;
            if (obs !== req) begin
                nbad++;
                $display("FAIL %s: got %h want %h", e.name, obs, req);
            end
            if (c == 3) begin
                ncmp++;
                if (cnt_b !== 32'd2) begin
                    nbad++;
                    $display("FAIL lu2_cnt: got %0d want 2", cnt_b);
                end
            end
            @(negedge clk);
        end
        defaults();
    endtask

    task automatic test_lat2_separated();
        exp_t e;
        logic [65:0] obs, req;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
                1: set_dec(1, 0, 0, 0, 0, 10, 1, 0, 0);
                2: set_dec(1, 0, 0, 0, 0, 11, 1, 0, 0);
                default: set_dec(1, 5, 1, 1, 1, 6, 1, 0, 0);
            endcase
            if (c == 3)
                exp_q.push_back(mk("sep_use", 1, 1, 0, 1,
                                   32'hB000_0002, RGF2));
            else
                exp_q.push_back(mk("sep_fill", 1, 1, 0, 1, RGF1, RGF2));
            #2;
            e = exp_q.pop_front();
            obs = {stall_b, issue_b, rs1_b, rs2_b};
            req = {e.stall, e.issue, e.r1, e.r2};
            ncmp++;
            if (obs !== req) begin
                nbad++;
                $display("FAIL %s: got %h want %h", e.name, obs, req);
            end
            if (c == 3) begin
                ncmp++;
                if (cnt_b !== 32'd0) begin
                    nbad++;
                    $display("FAIL sep_cnt: got %0d want 0", cnt_b);
                end
            end
            @(negedge clk);
        end
        defaults();
    endtask

    task automatic test_youngest();
        exp_t e;
        logic [65:0] obs, req;
        do_reset();
        fwd_a = {32'h0000_5555, 32'h0000_1BBB, 32'h0000_AAAA};
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin
                    set_dec(1, 0, 0, 0, 0, 7, 1, 0, 0);
                    exp_q.push_back(mk("yg_alu7", 0, 1, 0, 1, RGF1, RGF2));
                end
                1: begin
                    set_dec(1, 7, 0, 1, 0, 9, 1, 0, 0);
                    exp_q.push_back(mk("yg_alu_fwd", 0, 1, 0, 1,
                                       32'h0000_AAAA, RGF2));
                end
                2: begin
                    set_dec(1, 0, 0, 0, 0, 7, 1, 0, 0);
                    exp_q.push_back(mk("yg_alu7b", 0, 1, 0, 1, RGF1, RGF2));
                end
                3: begin
                    set_dec(1, 7, 7, 1, 1, 0, 0, 0, 0);
                    exp_q.push_back(mk("yg_both", 0, 1, 0, 1,
                                       32'h0000_AAAA, 32'h0000_AAAA));
                end
                default: begin
                    set_dec(1, 7, 7, 0, 1, 0, 0, 0, 0);
                    exp_q.push_back(mk("yg_re_gate", 0, 1, 0, 1,
                                       RGF1, 32'h0000_1BBB));
                end
            endcase
            #2;
            e = exp_q.pop_front();
            obs = {stall_a, issue_a, rs1_a, rs2_a};
            req = {e.stall, e.issue, e.r1, e.r2};
            ncmp++;
            if (obs !== req) begin
                nbad++;
                $display("FAIL %s: got %h want %h", e.name, obs, req);
            end
            @(negedge clk);
        end
        defaults();
    endtask

    task automatic test_x0();
        exp_t e;
        logic [65:0] obs, req;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                set_dec(1, 0, 0, 0, 0, 0, 1, 1, 0);
                exp_q.push_back(mk("x0_prod", 0, 1, 0, 1, RGF1, RGF2));
            end else begin
                fwd_a[31:0] = 32'h0000_1234;
                rgf_rd1 = 32'd0;
                set_dec(1, 0, 0, 1, 1, 6, 1, 0, 0);
                exp_q.push_back(mk("x0_read", 0, 1, 0, 1, 32'd0, RGF2));
            end
            #2;
            e = exp_q.pop_front();
            obs = {stall_a, issue_a, rs1_a, rs2_a};
            req = {e.stall, e.issue, e.r1, e.r2};
            ncmp++;
            if (obs !== req) begin
                nbad++;
                $display("FAIL %s: got %h want %h", e.name, obs, req);
            end
            @(negedge clk);
        end
        defaults();
    endtask

    task automatic test_flush();
        exp_t e;
        logic [65:0] obs, req;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: begin
                    set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
                    exp_q.push_back(mk("fl_load", 0, 1, 0, 1, RGF1, RGF2));
                end
                1: begin
                    set_dec(1, 5, 0, 1, 0, 8, 1, 1, 1);
                    exp_q.push_back(mk("fl_kill", 0, 0, 0, 0, 0, 0));
                end
                default: begin
                    set_dec(1, 8, 5, 1, 1, 9, 1, 0, 0);
                    exp_q.push_back(mk("fl_bubble", 0, 1, 0, 1,
                                       RGF1, 32'hA000_0001));
                end
            endcase
            #2;
            e = exp_q.pop_front();
            obs = {stall_a, issue_a, rs1_a, rs2_a};
            req = {e.stall, e.issue, e.r1, e.r2};
            if (!e.chk) begin obs[63:0] = '0; req[63:0] = '0; end
            ncmp++;
            if (obs !== req) begin
                nbad++;
                $display("FAIL %s: got %h want %h", e.name, obs, req);
            end
            if (c == 2) begin
                ncmp++;
                if (cnt_a !== 4'd0) begin
                    nbad++;
                    $display("FAIL fl_cnt: got %0d want 0", cnt_a);
                end
            end
            @(negedge clk);
        end
        defaults();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [65:0] obs, req;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0, 3: begin
                    set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
                    exp_q.push_back(mk("rm_load", 0, 1, 0, 1, RGF1, RGF2));
                end
                1, 4: begin
                    set_dec(1, 5, 1, 1, 1, 6, 1, 0, 0);
                    exp_q.push_back(mk("rm_stall", 0, 0, 1, 0, 0, 0));
                end
                2: exp_q.push_back(mk("rm_issue", 0, 1, 0, 1,
                                      32'hA000_0001, RGF2));
                default: begin
                    set_dec(1, 6, 0, 1, 0, 0, 0, 0, 0);
                    exp_q.push_back(mk("rm_after", 0, 1, 0, 1,
                                       32'hA000_0000, RGF2));
                end
            endcase
            #2;
            e = exp_q.pop_front();
            obs = {stall_a, issue_a, rs1_a, rs2_a};
            req = {e.stall, e.issue, e.r1, e.r2};
            if (!e.chk) begin obs[63:0] = '0; req[63:0] = '0; end
            ncmp++;
            if (obs !== req) begin
                nbad++;
                $display("FAIL %s: got %h want %h", e.name, obs, req);
            end
            if (c == 4) begin
                ncmp++;
                if (cnt_a !== 4'd1) begin
                    nbad++;
                    $display("FAIL rm_cnt_pre: got %0d want 1", cnt_a);
                end
                rst = 1'b1;
                #1;
                rst = 1'b0;
                #1;
                exp_q.push_back(mk("rm_post_rst", 0, 1, 0, 1, RGF1, RGF2));
                e = exp_q.pop_front();
                obs = {stall_a, issue_a, rs1_a, rs2_a};
                req = {e.stall, e.issue, e.r1, e.r2};
                ncmp++;
                if (obs !== req || cnt_a !== 4'd0) begin
                    nbad++;
                    $display("FAIL %s: got %h cnt %0d want %h cnt 0",
                             e.name, obs, cnt_a, req);
                end
            end
            @(negedge clk);
        end
        defaults();
    endtask

    task automatic test_back_to_back_saturate();
        exp_t e;
        logic [65:0] obs, req;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0);
            @(negedge clk);
            set_dec(1, 5, 5, 1, 1, 6, 1, 0, 0);
            exp_q.push_back(mk("sat_stall", 0, 0, 1, 0, 0, 0));
            #2;
            e = exp_q.pop_front();
            obs = {stall_a, issue_a, 64'd0};
            req = {e.stall, e.issue, 64'd0};
            ncmp++;
            if (obs !== req) begin
                nbad++;
                $display("FAIL %s[%0d]: got %h want %h", e.name, i, obs, req);
            end
            if (i == 16) begin
                ncmp++;
                if (cnt_a !== 4'hF) begin
                    nbad++;
                    $display("FAIL sat_during: got %h want f", cnt_a);
                end
            end
            @(negedge clk);
            @(negedge clk);
        end
        ncmp++;
        if (cnt_a !== 4'hF) begin
            nbad++;
            $display("FAIL sat_final: got %h want f", cnt_a);
        end
        defaults();
    endtask

    initial begin
        test_reset();
        test_load_use_lat1();
        test_load_use_lat2();
        test_lat2_separated();
        test_youngest();
        test_x0();
        test_flush();
        test_reset_mid();
        test_back_to_back_saturate();
        if (exp_q.size() != 0) begin
            nbad++;
            $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Parametrised hazard and forwarding unit for the decode stage. It tracks the destinations of in-flight instructions in a shift-register scoreboard of `DEPTH` slots (slot 0 = execute … slot `DEPTH-1` = writeback). For each decoded source operand it selects the youngest ready producer and raises a stall when that producer is a load whose data is not yet available. It generalises fixed ex/ma/wb forwarding to arbitrary pipeline depth and load latency, and adds issue tracking and a stall performance counter.

## Interface
- `XLEN`, 32, data width
- `DEPTH`, 3, in-flight slots between decode and regfile write; range 2..8
- `LD_LAT`, 1, first slot index at which load data is valid on `fwd_dat`; range 1..`DEPTH-1`
- `CNT_W`, 32, stall counter width
- `clk` in 1: clock
- `rst` in 1: asynchronous reset, active-high
- `dec_vld` in 1: decode holds a valid instruction
- `dec_rs1`, `dec_rs2` in 5 each: source register indices
- `dec_rs1_re`, `dec_rs2_re` in 1 each: source is actually read
- `dec_rd` in 5: destination register index
- `dec_we` in 1: instruction writes `dec_rd`
- `dec_is_load` in 1: instruction is a load
- `flush` in 1: branch flush; kills the instruction in decode
- `rgf_rd1`, `rgf_rd2` in `XLEN` each: regfile read data
- `fwd_dat` in `DEPTH*XLEN`: per-slot result data; slot k occupies bits [k*XLEN +: XLEN]
- `rs1_dat`, `rs2_dat` out `XLEN` each: resolved operands
- `stall` out 1: hold fetch/decode and insert a bubble
- `issue` out 1: instruction enters slot 0 this cycle
- `stall_cnt` out `CNT_W`: saturating count of stall cycles

## Operation
- Slot state (registered): `vld`, `rd`, `we`, `ld`.
- Every clock, slot k shifts to slot k+1, and slot `DEPTH-1` retires. The downstream pipeline never back-pressures.
- `issue = dec_vld & ~stall & ~flush`.
  - Slot 0 loads {1, `dec_rd`, `dec_we`, `dec_is_load`} when `issue` is high.
  - Otherwise slot 0 loads an invalid entry (bubble).
- Slot k matches source s when: `vld & we & rd!=0 & rd==s & s_re`.
- The youngest (lowest k) match wins; older matches are ignored.
- A winning slot is not ready when `ld & k<LD_LAT`. A non-load is ready in every slot.
- `stall = dec_vld & ~flush & (rs1 winner not ready | rs2 winner not ready)`.
- Operand select:
  - Winner ready → `fwd_dat` slice of the winning slot.
  - No winner, or register x0 → `rgf_rdN`.
  - Reads of x0 return `rgf_rdN` unmodified; the regfile supplies 0 for x0.
- `stall_cnt` increments when `stall` is high and saturates at all-ones.
- Simultaneous events:
  - `flush` with a pending hazard: flush wins, so `stall` and `issue` are both 0 and a bubble is inserted.
  - Both sources hazard: a single stall.
  - rs1==rs2: both outputs use the same winner.
- `rst` asserted mid-operation clears all slots immediately; the next `dec_vld` issues without stall.
- Reset values: all slot `vld`=0, `stall_cnt`=0.
  - Therefore `stall`=0, `issue=dec_vld&~flush`, and `rsN_dat=rgf_rdN`.

## Timing
- `stall`, `issue`, `rs1_dat` and `rs2_dat` are combinational from inputs and slot state, with zero latency. No combinational path from `fwd_dat` to `stall`.
- Slot state and `stall_cnt` update on the rising edge of `clk`.
- A load issued in cycle t sits in slot 0 at t+1 and reaches slot `LD_LAT` at t+1+`LD_LAT`.
  - A dependent instruction in decode at t+1 stalls for `LD_LAT` cycles.
  - It issues at t+1+`LD_LAT` with forwarded data.
- A load-use pair separated by ≥`LD_LAT` other instructions never stalls.
- An ALU producer never causes a stall.

## Structure
- Shared package `utils_top`:
  - Add `typedef struct packed {logic vld; logic [4:0] rd; logic we; logic ld;} sb_slot_t`.
  - Add constant `REG_ZERO = 5'd0`.
- One sub-module `decode_fwd_sel` (params `XLEN`, `DEPTH`, `LD_LAT`), instantiated once per source.
  - Inputs: slot array, source index, read-enable, `fwd_dat`, regfile data.
  - Outputs: `dat` and `hazard`.
- Top level holds the slot shift register, issue/stall logic and the counter.

## Test plan
- Load to x5 in slot 0, decode `add x6,x5,x1` with `LD_LAT`=1 → `stall`=1 for one cycle and `stall_cnt`=1; next cycle `rs1_dat`=`fwd_dat` slot 1.
- `LD_LAT`=2, `DEPTH`=4, same load-use pair → exactly 2 stall cycles, then issue; a pair separated by 2 instructions → 0 stalls.
- Slot 0 and slot 2 both write x7 (slot0 data 0xAAAA, slot2 data 0x5555), decode reads x7 on both ports → `rs1_dat`=`rs2_dat`=0xAAAA.
- Slot 0 writes x0 with `fwd_dat`=0x1234 and `rgf_rd1`=0, decode reads x0 → `rs1_dat`=0, no stall.
- Hazard pending and `flush`=1 in the same cycle → `stall`=0, `issue`=0, bubble in slot 0, `stall_cnt` unchanged.
- `rst` pulsed while a load is in slot 0 with a dependent in decode → next cycle `stall`=0, `issue`=1, `stall_cnt`=0; force `stall_cnt` to all-ones with `CNT_W`=4 → stays 0xF while stalling.
